matrix_frame_loader: RTL and testbench

// - Serial-in frame loader and row scanner for the 8x8 LED matrix player.
// - Accepts a 64-pixel frame over a 3-wire serial link (data, clock, latch) from an off-chip host.
// - Double-buffers the frame and multiplexes it onto one-hot row selects and 8 column lines.
// - Sits between the chip-level io_in pins and the io_out matrix drive pins.

---
 rtl/matrix_frame_loader_pkg.sv | 15 +
 rtl/matrix_input_sync.sv | 28 ++
 rtl/matrix_frame_loader.sv | 130 +++++++++++++
 tb/tb_matrix_frame_loader.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_frame_loader_pkg.sv
// Shared geometry constants for the 8x8 LED matrix frame loader.
package matrix_frame_loader_pkg;

  localparam int FRAME_BITS = 64;
  localparam int ROWS       = 8;
  localparam int COLS       = 8;
  localparam int ROW_W      = $clog2(ROWS);
  localparam int COL_W      = $clog2(COLS);
  localparam int CNT_W      = $clog2(FRAME_BITS) + 1;

  function automatic logic [ROWS-1:0] row_onehot(input logic [ROW_W-1:0] row);
    return ROWS'(1) << row;
  endfunction

endpackage

// File: rtl/matrix_input_sync.sv
// Multi-flop synchronizer for one asynchronous pin, followed by a rising-edge pulse.
module matrix_input_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] stage_reg;
  logic                   prev_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_reg <= '0;
      prev_reg  <= 1'b0;
    end else begin
      stage_reg <= {stage_reg[SYNC_STAGES-2:0], din};
      prev_reg  <= stage_reg[SYNC_STAGES-1];
    end
  end

  assign level = stage_reg[SYNC_STAGES-1];
  assign rise  = level & ~prev_reg;

endmodule

// File: rtl/matrix_frame_loader.sv
// Serial frame loader with double-buffered frame store and one-hot row scanner
// for an 8x8 LED matrix.
module matrix_frame_loader
  import matrix_frame_loader_pkg::*;
#(
  parameter int SCAN_DIV    = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ser_data,
  input  logic            ser_clk,
  input  logic            ser_latch,
  output logic [ROWS-1:0] row_sel,
  output logic [COLS-1:0] col_data,
  output logic            frame_valid,
  output logic            busy,
  output logic            err
);

  localparam int PRE_W = $clog2(SCAN_DIV);

  logic [2:0] pin_bus;
  logic [2:0] level_bus;
  logic [2:0] rise_bus;

  assign pin_bus = {ser_latch, ser_clk, ser_data};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      matrix_input_sync #(
        .SYNC_STAGES(SYNC_STAGES)
      ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (pin_bus[gi]),
        .level(level_bus[gi]),
        .rise (rise_bus[gi])
      );
    end
  endgenerate

  // Data travels through the same number of flops as the strobe, so its
  // synchronized level is already aligned with the strobe's edge pulse.
  logic data_level;
  logic clk_rise;
  logic latch_rise;
  logic sync_unused;

  assign data_level  = level_bus[0];
  assign clk_rise    = rise_bus[1];
  assign latch_rise  = rise_bus[2];
  assign sync_unused = &{level_bus[2:1], rise_bus[0], 1'b0};

  logic [CNT_W-1:0]      bit_cnt_reg;
  logic                  overflow_reg;
  logic                  busy_reg;
  logic                  err_reg;
  logic                  frame_valid_reg;
  logic [FRAME_BITS-1:0] back_reg;
  logic [FRAME_BITS-1:0] front_reg;
  logic [PRE_W-1:0]      presc_reg;
  logic [ROW_W-1:0]      row_reg;
  logic [ROWS-1:0]       row_sel_reg;
  logic [COLS-1:0]       col_data_reg;

  logic [ROW_W-1:0]      row_next;
  assign row_next = row_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt_reg     <= '0;
      overflow_reg    <= 1'b0;
      busy_reg        <= 1'b0;
      err_reg         <= 1'b0;
      frame_valid_reg <= 1'b0;
      back_reg        <= '0;
      front_reg       <= '0;
      presc_reg       <= '0;
      row_reg         <= '0;
      row_sel_reg     <= row_onehot('0);
      col_data_reg    <= '0;
    end else begin
      err_reg <= 1'b0;

      // A latch edge wins over a strobe edge arriving in the same cycle.
      if (latch_rise && !busy_reg) begin
        if (bit_cnt_reg == CNT_W'(FRAME_BITS) && !overflow_reg) begin
          busy_reg <= 1'b1;
        end else begin
          err_reg <= 1'b1;
        end
        bit_cnt_reg  <= '0;
        overflow_reg <= 1'b0;
      end else if (clk_rise && !busy_reg) begin
        if (bit_cnt_reg < CNT_W'(FRAME_BITS)) begin
          back_reg[bit_cnt_reg[CNT_W-2:0]] <= data_level;
          bit_cnt_reg                      <= bit_cnt_reg + 1'b1;
        end else begin
          overflow_reg <= 1'b1;
        end
      end

      if (presc_reg == PRE_W'(SCAN_DIV - 1)) begin
        presc_reg   <= '0;
        row_reg     <= row_next;
        row_sel_reg <= row_onehot(row_next);
        // Swap buffers only on the 7->0 wrap; row 0 is fed straight from the
        // incoming frame so the first lit row is never stale.
        if (row_reg == ROW_W'(ROWS - 1) && busy_reg) begin
          front_reg       <= back_reg;
          busy_reg        <= 1'b0;
          frame_valid_reg <= 1'b1;
          col_data_reg    <= back_reg[COLS-1:0];
        end else begin
          col_data_reg <= front_reg[{row_next, {COL_W{1'b0}}} +: COLS];
        end
      end else begin
        presc_reg <= presc_reg + 1'b1;
      end
    end
  end

  assign row_sel     = row_sel_reg;
  assign col_data    = col_data_reg;
  assign frame_valid = frame_valid_reg;
  assign busy        = busy_reg;
  assign err         = err_reg;

endmodule

// File: tb/tb_matrix_frame_loader.sv
// Randomized scoreboard bench: stimulus pushes expected commits/errors, a
// monitor checks them against the scanned matrix outputs.
module tb_matrix_frame_loader;

  localparam int SCAN_DIV = 4;
  localparam int SYNC     = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ser_data = 1'b0;
  logic       ser_clk = 1'b0;
  logic       ser_latch = 1'b0;
  logic [7:0] row_sel;
  logic [7:0] col_data;
  logic       frame_valid;
  logic       busy;
  logic       err;

  always #5 clk = ~clk;

  matrix_frame_loader #(
    .SCAN_DIV   (SCAN_DIV),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ser_data   (ser_data),
    .ser_clk    (ser_clk),
    .ser_latch  (ser_latch),
    .row_sel    (row_sel),
    .col_data   (col_data),
    .frame_valid(frame_valid),
    .busy       (busy),
    .err        (err)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          pending_bits[$];
  logic [63:0] commit_q[$];
  int          err_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a frame commits only when exactly 64 pixels arrived
  // since the last latch; pixel k lights row k/8, column k%8.
  task automatic model_latch();
    logic [63:0] f;
    f = '0;
    if (pending_bits.size() == 64) begin
      for (int k = 0; k < 64; k++) f[(k / 8) * 8 + (k % 8)] = pending_bits[k];
      commit_q.push_back(f);
      $display("latch: 64 bits -> commit %016h", f);
    end else begin
      err_q.push_back(pending_bits.size());
      $display("latch: %0d bits -> err", pending_bits.size());
    end
    pending_bits.delete();
  endtask

  // Monitor / scoreboard
  logic [63:0] disp;
  logic [7:0]  prev_row;
  logic [7:0]  prev_col;
  logic        prev_busy;
  logic        prev_err;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        disp      = '0;
        prev_row  = 8'h01;
        prev_col  = 8'h00;
        prev_busy = 1'b0;
        prev_err  = 1'b0;
      end else begin
        if (err) begin
          check("err_expected", 64'(err_q.size() > 0), 64'd1);
          if (err_q.size() > 0) void'(err_q.pop_front());
          check("err_one_cycle", 64'(prev_err), 64'd0);
        end
        if (row_sel != prev_row) begin
          int r;
          r = 0;
          check("row_advance", 64'(row_sel), 64'({prev_row[6:0], prev_row[7]}));
          if (prev_busy && !busy) begin
            check("commit_at_wrap", 64'(row_sel), 64'h01);
            check("commit_expected", 64'(commit_q.size() > 0), 64'd1);
            if (commit_q.size() > 0) disp = commit_q.pop_front();
            check("frame_valid", 64'(frame_valid), 64'd1);
          end
          for (int i = 0; i < 8; i++) if (row_sel[i]) r = i;
          check($sformatf("col_row%0d", r), 64'(col_data), 64'(disp[8 * r +: 8]));
        end else begin
          if (prev_busy && !busy) check("busy_fall_off_wrap", 64'(busy), 64'(prev_busy));
          if (col_data != prev_col) check("col_stable", 64'(col_data), 64'(prev_col));
        end
        prev_row  = row_sel;
        prev_col  = col_data;
        prev_busy = busy;
        prev_err  = err;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic shift_bit(input bit b);
    ser_data = b;
    cyc(2);
    ser_clk = 1'b1;
    cyc(3);
    ser_clk = 1'b0;
    cyc(3);
    pending_bits.push_back(b);
  endtask

  task automatic shift_random(input int n);
    for (int i = 0; i < n; i++) shift_bit(1'($urandom_range(0, 1)));
  endtask

  task automatic do_latch();
    model_latch();
    ser_latch = 1'b1;
    cyc(3);
    ser_latch = 1'b0;
    cyc(3);
  endtask

  task automatic simultaneous_latch();
    model_latch();
    ser_data  = 1'b1;
    ser_clk   = 1'b1;
    ser_latch = 1'b1;
    cyc(3);
    ser_clk   = 1'b0;
    ser_latch = 1'b0;
    cyc(3);
  endtask

  task automatic settle();
    for (int i = 0; i < 80; i++) begin
      if (!busy) break;
      cyc(1);
    end
    check("busy_timeout", 64'(busy), 64'd0);
    cyc(4);
    check("commit_q_drained", 64'(commit_q.size()), 64'd0);
    check("err_q_drained", 64'(err_q.size()), 64'd0);
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    ser_data  = 1'b0;
    ser_clk   = 1'b0;
    ser_latch = 1'b0;
    cyc(3);
    pending_bits.delete();
    commit_q.delete();
    err_q.delete();
    check("rst_row_sel", 64'(row_sel), 64'h01);
    check("rst_col_data", 64'(col_data), 64'h00);
    check("rst_frame_valid", 64'(frame_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    rst_n = 1'b1;
    cyc(1);
  endtask

  initial begin
    logic [7:0] pat;
    int         n;

    apply_reset();

    // Row 2 = A5, everything else dark
    pat = 8'hA5;
    for (int k = 0; k < 64; k++) shift_bit((k / 8 == 2) ? pat[k % 8] : 1'b0);
    do_latch();
    settle();
    cyc(40);
    check("frame_valid_after_a5", 64'(frame_valid), 64'd1);

    // Short frame
    shift_random(10);
    do_latch();
    settle();
    cyc(40);

    // Overflow, then a clean frame
    shift_random(70);
    do_latch();
    settle();
    shift_random(64);
    do_latch();
    settle();
    cyc(40);

    // Edges while busy must be ignored
    shift_random(64);
    for (int i = 0; i < 100; i++) begin
      if (row_sel == 8'h01) break;
      cyc(1);
    end
    check("row0_wait", 64'(row_sel), 64'h01);
    model_latch();
    ser_latch = 1'b1;
    cyc(3);
    check("busy_after_latch", 64'(busy), 64'd1);
    ser_latch = 1'b0;
    ser_data  = 1'b1;
    ser_clk   = 1'b1;
    cyc(3);
    ser_clk   = 1'b0;
    ser_latch = 1'b1;
    cyc(3);
    ser_latch = 1'b0;
    cyc(3);
    check("busy_held", 64'(busy), 64'd1);
    settle();
    cyc(40);

    // Simultaneous latch and strobe: the strobe's bit is dropped
    shift_random(63);
    simultaneous_latch();
    settle();
    shift_random(64);
    simultaneous_latch();
    settle();
    cyc(40);

    // Reset in the middle of a shift discards the partial frame
    shift_random(20);
    apply_reset();
    shift_random(64);
    do_latch();
    settle();
    cyc(40);

    // A few random frames, occasionally short
    for (int f = 0; f < 3; f++) begin
      n = ($urandom_range(0, 3) == 0) ? 62 : 64;
      shift_random(n);
      do_latch();
      settle();
      cyc(36);
    end

    check("frame_valid_final", 64'(frame_valid), 64'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
